fifo_uart_drain: RTL
====================

Name: fifo_uart_drain

Overview:
Read-side consumer for the team's 32-bit FIFO.
- Pops one word at a time over the FIFO's active-low Read / EMPTY / DataOut interface.
- Serializes each word as FIFOWIDTH/8 UART frames (8N1), least-significant byte first.
- Sits between the FIFO's DataOut and a board TX pin, on the same Clock domain.
- Like the FIFO, all state updates on the falling edge of Clock.

Parameters:
FIFOWIDTH, 32, word width from FIFO; must be a multiple of 8.
CLKS_PER_BIT, 434, Clock periods per UART bit. Minimum 2.
- Bit counter width is $clog2(CLKS_PER_BIT).

Ports:
Clock  input  1  system clock; logic updates on negedge.
Reset  input  1  asynchronous, active-low reset.
Enable  input  1  active-high; permits popping new words.
EMPTY  input  1  FIFO empty flag (1 = empty).
DataIn  input  FIFOWIDTH  FIFO DataOut; valid from the falling edge after Read was low.
Read  output  1  active-low pop strobe to FIFO; registered.
TxD  output  1  UART serial out; idle high.
Busy  output  1  high whenever state != IDLE.
ByteIdx  output  2  index of byte currently on the wire (0 = LSB byte).

Behaviour:
- Reset (Reset==0, async): state=IDLE; Read=1, TxD=1, Busy=0, ByteIdx=0; bit/clock counters and shift register cleared.
- Reset asserted mid-frame: TxD returns to 1 immediately. The partial word is discarded and not re-popped.
- States: IDLE, POP, LOAD, START, DATA, STOP.
- IDLE: if Enable && !EMPTY, go to POP and drive Read=0. Otherwise stay, with Read=1 and TxD=1.
- POP: lasts exactly one Clock; Read=1 on exit. Read is low for exactly one Clock period per word, never two consecutive.
- LOAD: on this falling edge, capture DataIn into the word register, set ByteIdx=0, go to START.
- START: TxD=0 for CLKS_PER_BIT clocks.
- DATA: 8 bits of byte ByteIdx, LSB first, each CLKS_PER_BIT clocks.
- STOP: TxD=1 for CLKS_PER_BIT clocks. Then:
  - if ByteIdx < FIFOWIDTH/8-1: increment ByteIdx, go to START (no idle gap between bytes);
  - else go to IDLE.
- Pop-to-first-start-bit latency: 2 Clocks (POP, LOAD). Minimum idle gap between words: 3 Clocks (IDLE, POP, LOAD), with TxD=1 throughout.
- Enable deasserted mid-word: the current word finishes completely; no further pops.
- EMPTY rising while not in IDLE: ignored. EMPTY is only sampled in IDLE.
- Read is never driven low while EMPTY=1 is sampled.
- Frame length per word: (FIFOWIDTH/8) × 10 × CLKS_PER_BIT Clocks; 40 × CLKS_PER_BIT at defaults.
- Clock-per-bit counter counts 0..CLKS_PER_BIT-1 and wraps at the bit boundary.

Optional Feature:
Macro UART_PARITY_EN.
- Defined: an even-parity bit (XOR of the 8 data bits) is inserted between the last data bit and the stop bit, via a PARITY state. Frame = 11 bits; word time = 44 × CLKS_PER_BIT at defaults.
- Undefined: plain 8N1 framing, and no PARITY state is synthesized.

Test Plan:
1. CLKS_PER_BIT=4, FIFO holds 0xA5C30F81, Enable=1 → exactly one 1-Clock Read low pulse, then four frames with bytes 0x81, 0x0F, 0xC3, 0xA5. Each frame: start 0, LSB-first data, stop 1. Total 160 Clocks; ByteIdx steps 0→3.
2. FIFO holds two words, 0x00000001 then 0xFFFFFFFF → two Read pulses separated by 3+160 Clocks. Second word's bytes are all 0xFF; TxD stays high for 3 Clocks between words.
3. EMPTY=1, Enable=1 for 500 Clocks → Read stays 1, TxD stays 1, Busy stays 0.
4. Enable dropped to 0 during byte 1 of word 0x12345678, with a second word queued → all bytes 0x78, 0x56, 0x34, 0x12 are sent, then IDLE. No second Read pulse until Enable returns to 1.
5. Reset pulsed low mid-DATA of byte 2 → TxD=1, Read=1, Busy=0 asynchronously. After release, the next word popped is the following FIFO entry.
6. With UART_PARITY_EN, byte 0x81 → parity bit 0. Byte 0x07 → parity bit 1; frame length is 11 bits.

Source files
------------

// File: rtl/fifo_uart_drain.sv
// ---------------------------------------------------------------------------
// fifo_uart_drain
//
// Read-side consumer for the 32-bit FIFO. Pops one word at a time over the
// FIFO's active-low Read / EMPTY / DataOut handshake. Each word goes out on
// TxD as FIFOWIDTH/8 back-to-back UART frames, least-significant byte first.
// All state changes on the falling edge of Clock, which matches the FIFO.
//
// Optional feature (compile-time macro UART_PARITY_EN):
//   defined   -> 8E1 framing. An even-parity bit is sent between the last
//                data bit and the stop bit (11-bit frame).
//   undefined -> plain 8N1 framing (10-bit frame). There is no parity state.
//
// Parameters:
//   FIFOWIDTH     word width from the FIFO. Must be a multiple of 8, <= 32.
//   CLKS_PER_BIT  Clock periods per UART bit. Must be >= 2.
//
// Ports:
//   Clock    in   system clock; logic updates on negedge
//   Reset    in   asynchronous, active-low reset
//   Enable   in   active-high; permits popping new words
//   EMPTY    in   FIFO empty flag (1 = empty); sampled only in IDLE
//   DataIn   in   FIFO DataOut; captured two falling edges after Read drops
//   Read     out  active-low pop strobe to FIFO, registered, one Clock wide
//   TxD      out  UART serial output, registered, idles high
//   Busy     out  high whenever the drain is not idle
//   ByteIdx  out  index of the byte currently on the wire (0 = LSB byte)
// ---------------------------------------------------------------------------
module fifo_uart_drain #(
    parameter int FIFOWIDTH    = 32,
    parameter int CLKS_PER_BIT = 434
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 Enable,
    input  logic                 EMPTY,
    input  logic [FIFOWIDTH-1:0] DataIn,
    output logic                 Read,
    output logic                 TxD,
    output logic                 Busy,
    output logic [1:0]           ByteIdx
);

    localparam int              CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [1:0]      LAST_BYTE = 2'(FIFOWIDTH / 8 - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_POP    = 3'd1;
    localparam logic [2:0] S_LOAD   = 3'd2;
    localparam logic [2:0] S_START  = 3'd3;
    localparam logic [2:0] S_DATA   = 3'd4;
    localparam logic [2:0] S_STOP   = 3'd5;
`ifdef UART_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd6;
`endif

    logic [2:0]           state;
    logic [CNT_W-1:0]     clk_cnt;   // Clocks elapsed within the current bit
    logic [2:0]           bit_cnt;   // data bit currently on the wire
    logic [FIFOWIDTH-1:0] word_sr;   // word being sent, shifted right per bit
`ifdef UART_PARITY_EN
    logic                 par_acc;   // XOR of the data bits sent so far
`endif

    logic bit_done;
    logic serial;

    assign bit_done = (clk_cnt == CNT_LAST);
    // The states from START upward time bits. IDLE, POP and LOAD do not.
    // An unused encoding also lands here, but it is sent to IDLE below.
    assign serial   = (state >= S_START);
    assign Busy     = (state != S_IDLE);

    // NOTE: Sequential state uses non-blocking assignments only, so every
    // register in this block samples the values from before the edge.
    always_ff @(negedge Clock or negedge Reset) begin
        if (!Reset) begin
            state   <= S_IDLE;
            Read    <= 1'b1;
            TxD     <= 1'b1;
            ByteIdx <= 2'd0;
            clk_cnt <= '0;
            bit_cnt <= 3'd0;
            // NOTE: The word register is reset with the control state. It is
            // a single register, not a memory, and a clean value makes a
            // mid-frame abort easy to see.
            word_sr <= '0;
`ifdef UART_PARITY_EN
            par_acc <= 1'b0;
`endif
        end else begin
            // The bit timer wraps at each bit boundary. It is always zero on
            // entry to START, because every exit from a serial state happens
            // on a wrap.
            if (serial) begin
                clk_cnt <= bit_done ? '0 : clk_cnt + 1'b1;
            end

            case (state)
                S_IDLE: begin
                    TxD  <= 1'b1;
                    Read <= 1'b1;
                    // EMPTY is only examined here. The strobe is never
                    // raised against an empty FIFO.
                    if (Enable && !EMPTY) begin
                        Read  <= 1'b0;
                        state <= S_POP;
                    end
                end

                S_POP: begin
                    // This state lasts one Clock, so Read is low for one
                    // Clock. The FIFO presents the word on this edge.
                    Read  <= 1'b1;
                    state <= S_LOAD;
                end

                S_LOAD: begin
                    word_sr <= DataIn;
                    ByteIdx <= 2'd0;
                    TxD     <= 1'b0;        // start bit of byte 0
                    state   <= S_START;
                end

                S_START: begin
                    if (bit_done) begin
                        bit_cnt <= 3'd0;
                        TxD     <= word_sr[0];
`ifdef UART_PARITY_EN
                        par_acc <= word_sr[0];
`endif
                        state   <= S_DATA;
                    end
                end

                S_DATA: begin
                    if (bit_done) begin
                        // After eight shifts the next byte sits in the low bits.
                        word_sr <= word_sr >> 1;
                        if (bit_cnt == 3'd7) begin
`ifdef UART_PARITY_EN
                            TxD   <= par_acc;
                            state <= S_PARITY;
`else
                            TxD   <= 1'b1;
                            state <= S_STOP;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            TxD     <= word_sr[1];
`ifdef UART_PARITY_EN
                            par_acc <= par_acc ^ word_sr[1];
`endif
                        end
                    end
                end

`ifdef UART_PARITY_EN
                S_PARITY: begin
                    if (bit_done) begin
                        TxD   <= 1'b1;
                        state <= S_STOP;
                    end
                end
`endif

                S_STOP: begin
                    if (bit_done) begin
                        if (ByteIdx < LAST_BYTE) begin
                            // The next byte starts at once, with no idle gap.
                            ByteIdx <= ByteIdx + 2'd1;
                            TxD     <= 1'b0;
                            state   <= S_START;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end

                default: begin
                    Read  <= 1'b1;
                    TxD   <= 1'b1;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
